// File: rtl/dc_ipu_pkg.sv
// Shared types and default widths for the IPU scaler address path.
package dc_ipu_pkg;

    localparam int unsigned DC_IPU_FRACT_WIDTH = 8;
    localparam int unsigned DC_IPU_INT_WIDTH   = 12;
    localparam int unsigned DC_IPU_LEN_WIDTH   = 12;

    typedef enum logic {
        IDLE,
        RUN
    } dc_ipu_addr_gen_state_e;

endpackage

// File: rtl/dc_ipu_step_accum.sv
// Accumulator: load takes priority and sets value to base; step adds inc (modulo 2^DATA_WIDTH).
module dc_ipu_step_accum #(
    parameter int unsigned DATA_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] inc,
    output logic [DATA_WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            value <= '0;
        end else if (load) begin
            value <= base;
        end else if (step) begin
            value <= value + inc;
        end
    end

endmodule

// File: rtl/dc_ipu_addr_compute_s2.sv
// Generates doubled, centre-aligned source coordinates (2i+1)*scale per output pixel,
// repeated for each line of a frame, behind a back-pressure tolerant output register.
module dc_ipu_addr_compute_s2 import dc_ipu_pkg::*; #(
    parameter int unsigned FRACT_WIDTH = DC_IPU_FRACT_WIDTH,
    parameter int unsigned INT_WIDTH   = DC_IPU_INT_WIDTH,
    parameter int unsigned DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH + 1,
    parameter int unsigned LEN_WIDTH   = DC_IPU_LEN_WIDTH
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           clr,
    input  logic                           start,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] cfg_scale,
    input  logic [LEN_WIDTH-1:0]           cfg_len,
    input  logic [LEN_WIDTH-1:0]           cfg_lines,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic                           out_frame_last
);

    dc_ipu_addr_gen_state_e state_q, state_d;

    logic [INT_WIDTH+FRACT_WIDTH-1:0] scale_q;
    logic [LEN_WIDTH-1:0]             len_q, lines_q;
    logic [LEN_WIDTH-1:0]             px_cnt_q, ln_cnt_q;
    logic [DATA_WIDTH-1:0]            acc, acc_base, acc_inc;
    logic                             start_ok, adv, line_end, frame_end;
    logic                             acc_load, acc_step;

    assign start_ok  = (state_q == IDLE) && start && !clr
                       && (cfg_len != '0) && (cfg_lines != '0);
    assign line_end  = (px_cnt_q == len_q - LEN_WIDTH'(1));
    assign frame_end = line_end && (ln_cnt_q == lines_q - LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN:  if (adv && frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    always_comb begin
        adv  = (state_q == RUN) && !clr && (!out_valid || out_ready);
        busy = (state_q == RUN) || out_valid;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            scale_q  <= '0;
            len_q    <= '0;
            lines_q  <= '0;
            px_cnt_q <= '0;
            ln_cnt_q <= '0;
        end else if (clr) begin
            px_cnt_q <= '0;
            ln_cnt_q <= '0;
        end else if (start_ok) begin
            scale_q  <= cfg_scale;
            len_q    <= cfg_len;
            lines_q  <= cfg_lines;
            px_cnt_q <= '0;
            ln_cnt_q <= '0;
        end else if (adv) begin
            if (line_end) begin
                px_cnt_q <= '0;
                ln_cnt_q <= ln_cnt_q + LEN_WIDTH'(1);
            end else begin
                px_cnt_q <= px_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // Line end reloads scale so the next line's first beat follows with no bubble.
    assign acc_load = clr || start_ok || (adv && line_end);
    assign acc_step = adv && !line_end;
    assign acc_base = clr      ? '0
                    : start_ok ? DATA_WIDTH'(cfg_scale)
                    :            DATA_WIDTH'(scale_q);
    assign acc_inc  = DATA_WIDTH'({scale_q, 1'b0});

    dc_ipu_step_accum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_accum (
        .clk   (clk),
        .nreset(nreset),
        .load  (acc_load),
        .step  (acc_step),
        .base  (acc_base),
        .inc   (acc_inc),
        .value (acc)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_last       <= 1'b0;
            out_frame_last <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid      <= 1'b1;
            out_data       <= acc;
            out_last       <= line_end;
            out_frame_last <= frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dc_ipu_addr_compute_s2.sv
// Scoreboard bench: stimulus pushes hand-computed beats, a negedge monitor pops and compares.
module tb_dc_ipu_addr_compute_s2;

    localparam int F = 8;
    localparam int I = 12;
    localparam int D = 21;
    localparam int L = 12;

    typedef struct packed {
        logic [D-1:0] data;
        logic         last;
        logic         flast;
    } beat_t;

    logic         clk = 1'b0;
    logic         nreset, clr, start;
    logic [I+F-1:0] cfg_scale;
    logic [L-1:0] cfg_len, cfg_lines;
    logic         busy, out_valid, out_ready, out_last, out_frame_last;
    logic [D-1:0] out_data;

    beat_t exp_q[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    popped     = 0;
    int    ready_mode = 1;
    bit    nobubble   = 1'b0;

    dc_ipu_addr_compute_s2 #(
        .FRACT_WIDTH(F),
        .INT_WIDTH  (I),
        .DATA_WIDTH (D),
        .LEN_WIDTH  (L)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .clr           (clr),
        .start         (start),
        .cfg_scale     (cfg_scale),
        .cfg_len       (cfg_len),
        .cfg_lines     (cfg_lines),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_frame_last(out_frame_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Sink readiness: 0 = low, 1 = high, 2 = toggle each cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ~out_ready;
            endcase
        end
    end

    initial begin : monitor
        beat_t e;
        beat_t held;
        bit    hold     = 1'b0;
        bit    in_frame = 1'b0;
        bit    chk_busy = 1'b0;
        int    cyc      = 0;
        int    last_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!nreset) begin
                hold     = 1'b0;
                in_frame = 1'b0;
                chk_busy = 1'b0;
            end else begin
                if (chk_busy) begin
                    check("busy_after_frame_last", 32'(busy), 32'(0));
                    chk_busy = 1'b0;
                end
                if (!busy) in_frame = 1'b0;
                if (out_valid) begin
                    check("busy_while_valid", 32'(busy), 32'(1));
                    if (hold) begin
                        check("stall_hold_data", 32'(out_data), 32'(held.data));
                        check("stall_hold_flags", 32'({out_last, out_frame_last}),
                              32'({held.last, held.flast}));
                    end
                    if (out_ready) begin
                        hold = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat at %0t",
                                     out_data, $time);
                        end else begin
                            e = exp_q.pop_front();
                            popped++;
                            check("out_data", 32'(out_data), 32'(e.data));
                            check("out_last", 32'(out_last), 32'(e.last));
                            check("out_frame_last", 32'(out_frame_last), 32'(e.flast));
                            if (nobubble && in_frame)
                                check("beat_gap_cycles", 32'(cyc - last_cyc), 32'(1));
                            last_cyc = cyc;
                            in_frame = !out_frame_last;
                            if (out_frame_last) chk_busy = 1'b1;
                        end
                    end else begin
                        hold = 1'b1;
                        held = '{out_data, out_last, out_frame_last};
                    end
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [D-1:0] d, input logic l, input logic f);
        exp_q.push_back('{d, l, f});
    endtask

    task automatic pulse_start(input logic [I+F-1:0] s, input logic [L-1:0] n, input logic [L-1:0] m);
        cfg_scale = s;
        cfg_len   = n;
        cfg_lines = m;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        check("frame_beats_outstanding", 32'(exp_q.size()), 32'(0));
        check("frame_busy_end", 32'(busy), 32'(0));
        tick(2);
    endtask

    task automatic wait_popped(input int target, input int budget);
        int k = 0;
        while (popped < target && k < budget) begin
            tick();
            k++;
        end
        check("beats_accepted_in_budget", 32'(popped >= target), 32'(1));
    endtask

    task automatic push_basic();
        push(21'h000200, 1'b0, 1'b0);
        push(21'h000600, 1'b0, 1'b0);
        push(21'h000A00, 1'b0, 1'b0);
        push(21'h000E00, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        nreset    = 1'b0;
        clr       = 1'b0;
        start     = 1'b0;
        cfg_scale = '0;
        cfg_len   = '0;
        cfg_lines = '0;
        tick(2);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_last", 32'({out_last, out_frame_last}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        nreset = 1'b1;
        tick(2);

        // Basic line, unstalled
        nobubble   = 1'b1;
        ready_mode = 1;
        push_basic();
        pulse_start(20'h00200, 12'd4, 12'd1);
        check("busy_after_start", 32'(busy), 32'(1));
        wait_idle(50);

        // Line wrap, with a start pulse carrying other config mid-frame
        push(21'h000180, 1'b0, 1'b0);
        push(21'h000480, 1'b1, 1'b0);
        push(21'h000180, 1'b0, 1'b0);
        push(21'h000480, 1'b1, 1'b0);
        push(21'h000180, 1'b0, 1'b0);
        push(21'h000480, 1'b1, 1'b1);
        pulse_start(20'h00180, 12'd2, 12'd3);
        tick();
        pulse_start(20'h00999, 12'd7, 12'd2);
        wait_idle(50);

        // Back-pressure: ready low at start, then toggling
        nobubble   = 1'b0;
        ready_mode = 0;
        push_basic();
        pulse_start(20'h00200, 12'd4, 12'd1);
        ready_mode = 2;
        wait_idle(60);
        ready_mode = 1;
        tick(2);

        // Start gating: zero length, zero lines
        pulse_start(20'h00200, 12'd0, 12'd1);
        tick(5);
        check("gate_len0_busy", 32'(busy), 32'(0));
        check("gate_len0_valid", 32'(out_valid), 32'(0));
        pulse_start(20'h00200, 12'd4, 12'd0);
        tick(5);
        check("gate_lines0_busy", 32'(busy), 32'(0));
        check("gate_lines0_valid", 32'(out_valid), 32'(0));

        // Flush on the third beat while stalled, with a simultaneous start
        push_basic();
        target = popped + 2;
        pulse_start(20'h00200, 12'd4, 12'd1);
        wait_popped(target, 20);
        ready_mode = 0;
        clr        = 1'b1;
        start      = 1'b1;
        tick();
        clr   = 1'b0;
        start = 1'b0;
        exp_q.delete();
        check("flush_valid", 32'(out_valid), 32'(0));
        check("flush_busy", 32'(busy), 32'(0));
        ready_mode = 1;
        tick(4);
        check("flush_start_dropped_busy", 32'(busy), 32'(0));
        check("flush_start_dropped_valid", 32'(out_valid), 32'(0));
        nobubble = 1'b1;
        push_basic();
        pulse_start(20'h00200, 12'd4, 12'd1);
        wait_idle(50);

        // Asynchronous reset mid-line
        nobubble = 1'b0;
        push_basic();
        target = popped + 2;
        pulse_start(20'h00200, 12'd4, 12'd1);
        wait_popped(target, 20);
        nreset = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'(0));
        check("arst_data", 32'(out_data), 32'(0));
        check("arst_flags", 32'({out_last, out_frame_last}), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        exp_q.delete();
        tick();
        nreset = 1'b1;
        tick(5);
        check("post_rst_idle_busy", 32'(busy), 32'(0));
        check("post_rst_idle_valid", 32'(out_valid), 32'(0));
        nobubble = 1'b1;
        push_basic();
        pulse_start(20'h00200, 12'd4, 12'd1);
        wait_idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
